// File: rtl/bram_read_arbiter.sv
// Shares one BRAM read port between the coprocessor (priority) and host requesters,
// with host starvation guard. Optional perf counters under BRAM_ARB_PERF_EN.
module bram_read_arbiter #(
  parameter int DATA_WIDTH       = 80,
  parameter int ADDR_WIDTH       = 9,
  parameter int STARVE_LIMIT     = 8,
  parameter int STARVE_CNT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cp_req_valid,
  output logic                  cp_req_ready,
  input  logic [ADDR_WIDTH-1:0] cp_req_addr,
  output logic                  cp_rsp_valid,
  input  logic                  cp_rsp_ready,
  output logic [DATA_WIDTH-1:0] cp_rsp_data,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic [ADDR_WIDTH-1:0] host_req_addr,
  output logic                  host_rsp_valid,
  input  logic                  host_rsp_ready,
  output logic [DATA_WIDTH-1:0] host_rsp_data,
  input  logic                  host_only,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic                  mem_r_valid,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
`ifdef BRAM_ARB_PERF_EN
  input  logic                  cnt_clr,
  output logic [31:0]           cp_grant_cnt,
  output logic [31:0]           host_grant_cnt,
  output logic [31:0]           stall_cnt,
`endif
  output logic                  busy
);

  localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_LIM = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  logic                        inflight_cp, inflight_host;
  logic                        hold_valid_cp, hold_valid_host;
  logic [DATA_WIDTH-1:0]       hold_data_cp, hold_data_host;
  logic [STARVE_CNT_WIDTH-1:0] host_wait;

  logic drain_cp, drain_host, slot_ok_cp, slot_ok_host;
  logic elig_cp, elig_host, grant_cp, grant_host;

  assign cp_rsp_valid   = inflight_cp | hold_valid_cp;
  assign host_rsp_valid = inflight_host | hold_valid_host;
  assign drain_cp       = cp_rsp_valid & cp_rsp_ready;
  assign drain_host     = host_rsp_valid & host_rsp_ready;
  assign slot_ok_cp     = ~cp_rsp_valid | drain_cp;
  assign slot_ok_host   = ~host_rsp_valid | drain_host;

  // Grants are gated by rst_n so every output is 0 while reset is held.
  assign elig_cp   = rst_n & cp_req_valid & slot_ok_cp & ~host_only;
  assign elig_host = rst_n & host_req_valid & slot_ok_host;

  always_comb begin
    grant_cp   = 1'b0;
    grant_host = 1'b0;
    if (elig_cp && elig_host) begin
      if (host_wait >= STARVE_LIM) grant_host = 1'b1;
      else                         grant_cp   = 1'b1;
    end else begin
      grant_cp   = elig_cp;
      grant_host = elig_host;
    end
  end

  assign cp_req_ready   = grant_cp;
  assign host_req_ready = grant_host;
  assign mem_r_valid    = grant_cp | grant_host;
  assign mem_r_addr     = grant_cp   ? cp_req_addr   :
                          grant_host ? host_req_addr : '0;

  assign cp_rsp_data   = hold_valid_cp   ? hold_data_cp   :
                         inflight_cp     ? mem_r_data     : '0;
  assign host_rsp_data = hold_valid_host ? hold_data_host :
                         inflight_host   ? mem_r_data     : '0;

  assign busy = inflight_cp | inflight_host | hold_valid_cp | hold_valid_host;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_cp     <= 1'b0;
      inflight_host   <= 1'b0;
      hold_valid_cp   <= 1'b0;
      hold_valid_host <= 1'b0;
      hold_data_cp    <= '0;
      hold_data_host  <= '0;
    end else begin
      inflight_cp   <= grant_cp;
      inflight_host <= grant_host;
      // Unconsumed BRAM word must be captured now; mem_r_data is only valid one cycle.
      if (inflight_cp && !drain_cp) begin
        hold_valid_cp <= 1'b1;
        hold_data_cp  <= mem_r_data;
      end else if (drain_cp) begin
        hold_valid_cp <= 1'b0;
      end
      if (inflight_host && !drain_host) begin
        hold_valid_host <= 1'b1;
        hold_data_host  <= mem_r_data;
      end else if (drain_host) begin
        hold_valid_host <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_wait <= '0;
    end else if (grant_host || !host_req_valid) begin
      host_wait <= '0;
    end else if (slot_ok_host && (host_wait != '1)) begin
      host_wait <= host_wait + 1'b1;
    end
  end

`ifdef BRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_grant_cnt   <= '0;
      host_grant_cnt <= '0;
      stall_cnt      <= '0;
    end else if (cnt_clr) begin
      cp_grant_cnt   <= '0;
      host_grant_cnt <= '0;
      stall_cnt      <= '0;
    end else begin
      if (grant_cp && (cp_grant_cnt != '1))     cp_grant_cnt   <= cp_grant_cnt + 1'b1;
      if (grant_host && (host_grant_cnt != '1)) host_grant_cnt <= host_grant_cnt + 1'b1;
      if ((cp_req_valid || host_req_valid) && !mem_r_valid && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
